// File: rtl/game_hvsync_gen2.sv
// Parametrised VGA timing generator: sync/blank decode, x/y, line/frame pulses,
// frame counter, N-stage en-gated output pipeline. Optional GAME_HVSYNC_GEN2_TEST_PATTERN_EN adds rgb bars.
module game_hvsync_gen2 #(
  parameter int X_WIDTH         = 10,
  parameter int Y_WIDTH         = 10,
  parameter int SCREEN_WIDTH    = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int SCREEN_HIGHT    = 480,
  parameter int V_BOTTOM        = 10,
  parameter int V_SYNC          = 2,
  parameter int V_TOP           = 33,
  parameter int N_PIPE_STAGES   = 1,
  parameter bit HSYNC_POL       = 1'b0,
  parameter bit VSYNC_POL       = 1'b0,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       display_on,
  output logic [X_WIDTH-1:0]         x,
  output logic [Y_WIDTH-1:0]         y,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
`ifdef GAME_HVSYNC_GEN2_TEST_PATTERN_EN
  ,
  output logic [2:0]                 rgb
`endif
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HIGHT + V_BOTTOM + V_SYNC + V_TOP;
  localparam int NP      = N_PIPE_STAGES;

  localparam logic [X_WIDTH-1:0] H_MAX    = X_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_VIS    = X_WIDTH'(SCREEN_WIDTH);
  localparam logic [X_WIDTH-1:0] HS_FIRST = X_WIDTH'(SCREEN_WIDTH + H_FRONT);
  localparam logic [X_WIDTH-1:0] HS_LAST  = X_WIDTH'(SCREEN_WIDTH + H_FRONT + H_SYNC - 1);
  localparam logic [Y_WIDTH-1:0] V_MAX    = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_VIS    = Y_WIDTH'(SCREEN_HIGHT);
  localparam logic [Y_WIDTH-1:0] VS_FIRST = Y_WIDTH'(SCREEN_HIGHT + V_BOTTOM);
  localparam logic [Y_WIDTH-1:0] VS_LAST  = Y_WIDTH'(SCREEN_HIGHT + V_BOTTOM + V_SYNC - 1);

  if ((H_TOTAL - 1) >= (1 << X_WIDTH)) begin : g_bad_xw
    $error("game_hvsync_gen2: X_WIDTH too small for H_TOTAL-1");
  end
  if ((V_TOTAL - 1) >= (1 << Y_WIDTH)) begin : g_bad_yw
    $error("game_hvsync_gen2: Y_WIDTH too small for V_TOTAL-1");
  end
  if (NP < 1) begin : g_bad_np
    $error("game_hvsync_gen2: N_PIPE_STAGES must be 1 or more");
  end
`ifdef GAME_HVSYNC_GEN2_TEST_PATTERN_EN
  if (X_WIDTH < 9) begin : g_bad_rgb
    $error("game_hvsync_gen2: test pattern needs X_WIDTH >= 9");
  end
`endif

  typedef struct packed {
    logic                       hs;
    logic                       vs;
    logic                       de;
    logic [X_WIDTH-1:0]         x;
    logic [Y_WIDTH-1:0]         y;
    logic                       ls;
    logic                       fs;
    logic [FRAME_CNT_WIDTH-1:0] fc;
  } tuple_t;

  localparam tuple_t IDLE_T = '{hs: ~HSYNC_POL, vs: ~VSYNC_POL, default: '0};

  logic [X_WIDTH-1:0]         h_q, h_d;
  logic [Y_WIDTH-1:0]         v_q, v_d;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  tuple_t                     dec;
  tuple_t                     pipe_q [NP];

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    if (en) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) begin
          v_d    = '0;
          fcnt_d = fcnt_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      v_q    <= '0;
      fcnt_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    dec    = IDLE_T;
    dec.hs = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    dec.vs = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    dec.de = (h_q < H_VIS) && (v_q < V_VIS);
    dec.x  = h_q;
    dec.y  = v_q;
    dec.ls = (h_q == '0);
    dec.fs = (h_q == '0) && (v_q == '0);
    dec.fc = fcnt_q;
  end

  for (genvar g = 0; g < NP; g++) begin : g_stage
    tuple_t src;
    if (g == 0) begin : g_from_dec
      always_comb src = dec;
    end else begin : g_from_prev
      always_comb src = pipe_q[g-1];
    end

    if (g == NP - 1) begin : g_last
      // Pulses are dropped on any idle clk so they mark only the arrival edge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_q[g] <= IDLE_T;
        end else if (en) begin
          pipe_q[g] <= src;
        end else begin
          pipe_q[g].ls <= 1'b0;
          pipe_q[g].fs <= 1'b0;
        end
      end
`ifdef GAME_HVSYNC_GEN2_TEST_PATTERN_EN
      logic [2:0] rgb_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rgb_q <= '0;
        end else if (en) begin
          rgb_q <= src.de ? src.x[8:6] : 3'b000;
        end
      end
      assign rgb = rgb_q;
`endif
    end else begin : g_mid
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_q[g] <= IDLE_T;
        end else if (en) begin
          pipe_q[g] <= src;
        end
      end
    end
  end

  assign hsync       = pipe_q[NP-1].hs;
  assign vsync       = pipe_q[NP-1].vs;
  assign display_on  = pipe_q[NP-1].de;
  assign x           = pipe_q[NP-1].x;
  assign y           = pipe_q[NP-1].y;
  assign line_start  = pipe_q[NP-1].ls;
  assign frame_start = pipe_q[NP-1].fs;
  assign frame_cnt   = pipe_q[NP-1].fc;

endmodule

// File: doc/game_hvsync_gen2.md
Name: game_hvsync_gen2

Overview:
- Second-generation parametrised VGA timing generator for the game designs.
- Produces hsync and vsync with configurable polarity, plus display_on and x/y pixel coordinates, through a configurable-depth output pipeline.
- Adds a pixel-clock enable, line and frame start pulses, and a frame counter for game logic such as sprite motion and random reseeding.
- Sits between clk/reset and the game's drawing logic in the top level.

Parameters:
- X_WIDTH, 10, width of x output and horizontal counter.
- Y_WIDTH, 10, width of y output and vertical counter.
- SCREEN_WIDTH, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BACK, 48, horizontal back porch.
- SCREEN_HIGHT, 480, visible lines.
- V_BOTTOM, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_TOP, 33, vertical back porch in lines.
- N_PIPE_STAGES, 1, output register depth; must be 1 or more.
- HSYNC_POL, 0, asserted level of hsync.
- VSYNC_POL, 0, asserted level of vsync.
- FRAME_CNT_WIDTH, 8, width of frame_cnt.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- en  input  1  pixel enable; counters and pipeline advance only when 1.
- hsync  output  1  horizontal sync, level set by HSYNC_POL.
- vsync  output  1  vertical sync, level set by VSYNC_POL.
- display_on  output  1  1 while (x, y) is in the visible area.
- x  output  X_WIDTH  horizontal position.
- y  output  Y_WIDTH  vertical position.
- line_start  output  1  one-clk pulse at x==0.
- frame_start  output  1  one-clk pulse at x==0, y==0.
- frame_cnt  output  FRAME_CNT_WIDTH  count of completed frames.

Behaviour:
- Totals:
  - H_TOTAL = SCREEN_WIDTH+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = SCREEN_HIGHT+V_BOTTOM+V_SYNC+V_TOP (default 525).
- Counters:
  - h runs 0..H_TOTAL-1, v runs 0..V_TOTAL-1.
  - On an en cycle, h increments; at H_TOTAL-1, h wraps to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0 and the internal frame count increments, modulo 2^FRAME_CNT_WIDTH.
- Decode:
  - display_on = h<SCREEN_WIDTH and v<SCREEN_HIGHT.
  - hsync is asserted for h in [SCREEN_WIDTH+H_FRONT, SCREEN_WIDTH+H_FRONT+H_SYNC-1].
  - vsync is asserted for v in [SCREEN_HIGHT+V_BOTTOM, SCREEN_HIGHT+V_BOTTOM+V_SYNC-1].
  - Asserted level = *_POL; deasserted level = ~*_POL.
  - x = h, y = v, including during blanking.
- Pipeline:
  - The decoded tuple (hsync, vsync, display_on, x, y, line_start, frame_start, frame_cnt) passes through N_PIPE_STAGES registers.
  - All stages shift only on en cycles.
  - A counter state appears on the outputs exactly N_PIPE_STAGES en cycles after it is current.
  - en=0 holds every counter, stage and output, except the pulses.
- Pulses:
  - line_start and frame_start are high for exactly one clk: the cycle in which their tuple first reaches the outputs.
  - They are forced to 0 on the next clk even when en=0, so they never stretch.
- frame_cnt:
  - Equals the number of frame wraps of the counter state carried in the same tuple.
  - Therefore the first frame_start after reset shows frame_cnt=0, the second shows 1, and so on.
  - Wraps from 2^FRAME_CNT_WIDTH-1 to 0.
- Reset (reset=0, asynchronous):
  - Counters are 0; all stages and outputs are cleared.
  - Output values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_on=0, x=0, y=0, pulses 0, frame_cnt=0.
  - Assertion mid-line or mid-frame takes effect immediately.
  - After release, the first en cycle loads the decode of (0,0) into stage 1.
- Constraint: X_WIDTH and Y_WIDTH must hold H_TOTAL-1 and V_TOTAL-1; an elaboration-time check fails otherwise. N_PIPE_STAGES=0 is illegal.

Optional Feature:
- Macro: GAME_HVSYNC_GEN2_TEST_PATTERN_EN.
- Defined:
  - Adds output rgb[2:0], registered as the last pipeline stage and aligned with x.
  - rgb = display_on ? x[8:6] : 3'b000, giving 64-pixel colour bars.
  - rgb resets to 0.
  - Requires X_WIDTH>=9.
- Undefined: the rgb port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, en=1, defaults:
  - First output tuple appears 1 clk after the first en edge: x=0, y=0, display_on=1, line_start=1, frame_start=1, frame_cnt=0, hsync=1, vsync=1.
- Line timing, en=1:
  - hsync=0 exactly for x=656..751 (96 clks).
  - display_on falls at x=640.
  - line_start repeats every 800 clks.
- Frame timing, en=1:
  - vsync=0 for y=490..491 (1600 clks).
  - frame_start every 420000 clks.
  - frame_cnt shows 1 on the second frame_start.
  - With FRAME_CNT_WIDTH=2, frame_cnt wraps 3 -> 0 on the fifth frame_start.
- en toggled 1,0,0,1 around x=799:
  - Outputs hold while en=0.
  - line_start is high for exactly one clk.
  - The x sequence is 798, 799, 0 with no skips.
- N_PIPE_STAGES=3, HSYNC_POL=1:
  - Outputs lag the N_PIPE_STAGES=1 reference model by exactly 2 en cycles.
  - hsync is high during the sync window.
- reset pulsed low at x=300, y=200:
  - Outputs show reset values on the same edge, asynchronously.
  - After release, the sequence restarts at (0,0) with frame_cnt=0.
